regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 95 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with busy scoreboard.
// Two writeback sources (src0 = ALU/execute, src1 = load/memory) share the
// single RegisterFile write port under round-robin arbitration. A per-register
// busy bit is set by the issue stage and cleared by the matching writeback,
// and the decode stage reads it to detect RAW/WAW hazards.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   src0_* / src1_*               valid/reg/data in, ready out (same-cycle grant)
//   issue_valid/issue_reg         mark a destination pending; issue_ready out
//   query_reg1/2, query_busy1/2   combinational scoreboard lookups
//   regWrite/writeRegister/writeData  RegisterFile write port
module regfile_wb_arbiter #(
  parameter int unsigned WordLen   = 32,
  parameter int unsigned WordCount = 32,
  localparam int unsigned AW = (WordCount > 1) ? $clog2(WordCount) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src0_valid,
  input  logic [AW-1:0]      src0_reg,
  input  logic [WordLen-1:0] src0_data,
  output logic               src0_ready,
  input  logic               src1_valid,
  input  logic [AW-1:0]      src1_reg,
  input  logic [WordLen-1:0] src1_data,
  output logic               src1_ready,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_reg,
  output logic               issue_ready,
  input  logic [AW-1:0]      query_reg1,
  input  logic [AW-1:0]      query_reg2,
  output logic               query_busy1,
  output logic               query_busy2,
  output logic               regWrite,
  output logic [AW-1:0]      writeRegister,
  output logic [WordLen-1:0] writeData
);

  logic [WordCount-1:0] busy_q, busy_d;
  // Index of the source granted most recently; 1 after reset so src0 wins first.
  logic                 rr_last_q, rr_last_d;
  logic                 grant0_c, grant1_c;

  // Arbitration, register-file port, scoreboard lookups and next state.
  always_comb begin
    grant0_c    = 1'b0;
    grant1_c    = 1'b0;
    busy_d      = busy_q;
    rr_last_d   = rr_last_q;

    if (!rst) begin
      if (src0_valid && src1_valid) begin
        grant0_c = rr_last_q;
        grant1_c = !rr_last_q;
      end else begin
        grant0_c = src0_valid;
        grant1_c = src1_valid;
      end
    end

    src0_ready    = grant0_c;
    src1_ready    = grant1_c;
    regWrite      = grant0_c | grant1_c;
    writeRegister = grant1_c ? src1_reg : src0_reg;
    writeData     = grant1_c ? src1_data : src0_data;

    // Checked against pre-edge busy, so an issue racing its own clear waits a cycle.
    issue_ready = !rst && (!busy_q[issue_reg] || (issue_reg == AW'(0)));
    query_busy1 = busy_q[query_reg1];
    query_busy2 = busy_q[query_reg2];

    if (regWrite) begin
      rr_last_d = grant1_c;
      busy_d[writeRegister] = 1'b0;
    end
    // Set after clear: a same-edge issue to the same register wins.
    if (issue_valid && issue_ready) begin
      busy_d[issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      rr_last_q <= 1'b1;
    end else begin
      busy_q    <= busy_d;
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int unsigned WL = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          src0_valid, src1_valid, issue_valid;
  logic [AW-1:0] src0_reg, src1_reg, issue_reg, query_reg1, query_reg2;
  logic [WL-1:0] src0_data, src1_data;
  logic          src0_ready, src1_ready, issue_ready, query_busy1, query_busy2;
  logic          regWrite;
  logic [AW-1:0] writeRegister;
  logic [WL-1:0] writeData;

  regfile_wb_arbiter #(.WordLen(WL), .WordCount(32)) dut (
    .clk(clk), .rst(rst),
    .src0_valid(src0_valid), .src0_reg(src0_reg), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_reg(src1_reg), .src1_data(src1_data), .src1_ready(src1_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .query_reg1(query_reg1), .query_reg2(query_reg2),
    .query_busy1(query_busy1), .query_busy2(query_busy2),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: set of pending registers and the last winner.
  bit       pending [32];
  int       last_winner;
  bit       model_known = 0;
  int       winner;          // -1 none, 0 src0, 1 src1
  bit       exp_issue_ok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Predict this cycle's behaviour and compare every output (called after negedge).
  task automatic cmp();
    #1;
    winner = -1;
    if (!rst) begin
      if (src0_valid && src1_valid) winner = (last_winner == 0) ? 1 : 0;
      else if (src0_valid)          winner = 0;
      else if (src1_valid)          winner = 1;
    end
    exp_issue_ok = !rst && (issue_reg == 0 || !pending[issue_reg]);
    check_eq("src0_ready", 32'(src0_ready), 32'(winner == 0));
    check_eq("src1_ready", 32'(src1_ready), 32'(winner == 1));
    check_eq("regWrite",   32'(regWrite),   32'(winner >= 0));
    check_eq("issue_ready", 32'(issue_ready), 32'(exp_issue_ok));
    if (winner >= 0) begin
      check_eq("writeRegister", 32'(writeRegister), 32'(winner == 1 ? src1_reg : src0_reg));
      check_eq("writeData", writeData, (winner == 1) ? src1_data : src0_data);
    end
    if (model_known) begin
      check_eq("query_busy1", 32'(query_busy1), 32'(pending[query_reg1]));
      check_eq("query_busy2", 32'(query_busy2), 32'(pending[query_reg2]));
    end
  endtask

  // Apply the clock edge to the model, then move to the next negedge.
  task automatic adv();
    int wreg;
    if (rst) begin
      foreach (pending[i]) pending[i] = 0;
      last_winner = 1;
      model_known = 1;
    end else begin
      if (winner >= 0) begin
        last_winner = winner;
        wreg = (winner == 1) ? int'(src1_reg) : int'(src0_reg);
        pending[wreg] = 0;
      end
      if (issue_valid && exp_issue_ok && issue_reg != 0) pending[issue_reg] = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; src0_valid = 0; src1_valid = 0; issue_valid = 0;
  endtask

  // Random-source pending transactions (held until accepted).
  bit            p0, p1;
  logic [AW-1:0] p0_reg, p1_reg;
  logic [WL-1:0] p0_data, p1_data;

  initial begin
    rst = 1; src0_valid = 1; src1_valid = 1; issue_valid = 1;
    src0_reg = 5'd1; src1_reg = 5'd2; issue_reg = 5'd3;
    src0_data = '0; src1_data = '0; query_reg1 = '0; query_reg2 = '0;
    last_winner = 1;
    @(negedge clk);

    // Reset held two cycles with everything requesting.
    for (int c = 0; c < 2; c++) begin
      cmp();
      check_eq("rst_src0_ready", 32'(src0_ready), 32'd0);
      check_eq("rst_src1_ready", 32'(src1_ready), 32'd0);
      check_eq("rst_regWrite",   32'(regWrite),   32'd0);
      check_eq("rst_issue_ready", 32'(issue_ready), 32'd0);
      adv();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      query_reg1 = 5'(i); query_reg2 = 5'(31 - i);
      cmp();
      check_eq("post_rst_busy1", 32'(query_busy1), 32'd0);
      check_eq("post_rst_busy2", 32'(query_busy2), 32'd0);
      adv();
    end

    // Single source src1.
    src1_valid = 1; src1_reg = 5'd5; src1_data = 32'hDEADBEEF;
    cmp();
    check_eq("single_src1_ready", 32'(src1_ready), 32'd1);
    check_eq("single_src0_ready", 32'(src0_ready), 32'd0);
    check_eq("single_regWrite", 32'(regWrite), 32'd1);
    check_eq("single_wreg", 32'(writeRegister), 32'd5);
    check_eq("single_wdata", writeData, 32'hDEADBEEF);
    adv();
    idle();

    // Round robin: src0, src1, src0, src1.
    src0_valid = 1; src1_valid = 1; src0_reg = 5'd3; src1_reg = 5'd4;
    for (int i = 0; i < 4; i++) begin
      src0_data = 32'h1000 + 32'(i); src1_data = 32'h2000 + 32'(i);
      cmp();
      check_eq("rr_src0_ready", 32'(src0_ready), 32'(i % 2 == 0));
      check_eq("rr_src1_ready", 32'(src1_ready), 32'(i % 2 == 1));
      check_eq("rr_wdata", writeData, (i % 2 == 0) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
      adv();
    end
    idle();

    // Scoreboard on reg 7.
    issue_valid = 1; issue_reg = 5'd7; query_reg1 = 5'd7;
    cmp(); check_eq("iss7_ready", 32'(issue_ready), 32'd1); adv();
    cmp();
    check_eq("iss7_busy", 32'(query_busy1), 32'd1);
    check_eq("iss7_waw", 32'(issue_ready), 32'd0);
    adv();
    issue_valid = 0; src0_valid = 1; src0_reg = 5'd7; src0_data = 32'h77;
    cmp();
    check_eq("wb7_ready", 32'(src0_ready), 32'd1);
    check_eq("wb7_busy_same", 32'(query_busy1), 32'd1);
    adv();
    idle();
    cmp(); check_eq("wb7_busy_after", 32'(query_busy1), 32'd0); adv();

    // Simultaneous set/clear on reg 9.
    issue_valid = 1; issue_reg = 5'd9; query_reg1 = 5'd9;
    cmp(); adv();
    src1_valid = 1; src1_reg = 5'd9; src1_data = 32'h99;
    cmp();
    check_eq("sc9_issue_ready", 32'(issue_ready), 32'd0);
    check_eq("sc9_src1_ready", 32'(src1_ready), 32'd1);
    adv();
    src1_valid = 0;
    cmp();
    check_eq("sc9_cleared", 32'(query_busy1), 32'd0);
    check_eq("sc9_issue_retry", 32'(issue_ready), 32'd1);
    adv();
    issue_valid = 0;
    cmp(); check_eq("sc9_busy_again", 32'(query_busy1), 32'd1); adv();

    // Register 0 never becomes busy.
    issue_valid = 1; issue_reg = 5'd0; query_reg1 = 5'd0;
    cmp(); check_eq("x0_issue_ready", 32'(issue_ready), 32'd1); adv();
    issue_valid = 0; src0_valid = 1; src0_reg = 5'd0; src0_data = 32'h5A5A;
    cmp();
    check_eq("x0_busy", 32'(query_busy1), 32'd0);
    check_eq("x0_wb_ready", 32'(src0_ready), 32'd1);
    check_eq("x0_regWrite", 32'(regWrite), 32'd1);
    check_eq("x0_wreg", 32'(writeRegister), 32'd0);
    adv();
    idle();

    // Reset mid-operation with reg 9 busy and requests pending.
    rst = 1; src0_valid = 1; src1_valid = 1; src0_reg = 5'd9; src1_reg = 5'd9;
    cmp(); check_eq("midrst_regWrite", 32'(regWrite), 32'd0); adv();
    idle(); query_reg1 = 5'd9;
    cmp(); check_eq("midrst_busy9", 32'(query_busy1), 32'd0); adv();

    // Randomized traffic; sources hold requests until accepted.
    p0 = 0; p1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!p0 && ($urandom % 2 == 1)) begin
        p0 = 1; p0_reg = 5'($urandom % 10); p0_data = $urandom;
      end
      if (!p1 && ($urandom % 2 == 1)) begin
        p1 = 1; p1_reg = 5'($urandom % 10); p1_data = $urandom;
      end
      rst = ($urandom % 150 == 0);
      src0_valid = p0; src0_reg = p0_reg; src0_data = p0_data;
      src1_valid = p1; src1_reg = p1_reg; src1_data = p1_data;
      issue_valid = ($urandom % 2 == 1);
      issue_reg   = 5'($urandom % 10);
      query_reg1  = 5'($urandom % 10);
      query_reg2  = 5'($urandom);
      cmp();
      if (winner == 0) p0 = 0;
      if (winner == 1) p1 = 0;
      adv();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
